// File: rtl/bp_wb_fifo_control.sv
// Bank-buffer write-back: streams two bank-group lines to the DDR write FIFO,
// with a skid buffer that absorbs bank read latency while the FIFO back-pressures.

module bp_wb_col #(
  parameter int X_MAC    = 4,
  parameter int ADDR_LEN = 16,
  parameter int DATA_LEN = 32
) (
  input  logic                               issue,
  input  logic [1:0]                         rd_grp,
  input  logic [ADDR_LEN-1:0]                rd_addr,
  input  logic [1:0]                         cap_grp,
  input  logic [X_MAC-1:0][DATA_LEN-1:0]     bank_data,
  output logic [X_MAC-1:0]                   rd_en,
  output logic [X_MAC-1:0][ADDR_LEN-1:0]     addr,
  output logic [DATA_LEN-1:0]                word
);
  for (genvar g = 0; g < X_MAC; g++) begin : g_grp
    assign rd_en[g] = issue && (rd_grp == 2'(g));
    assign addr[g]  = issue ? rd_addr : '0;
  end
  assign word = bank_data[cap_grp];
endmodule

module bp_wb_fifo_control #(
  parameter int X_MAC        = 4,
  parameter int X_MESH       = 16,
  parameter int DDR_ADDR_LEN = 32,
  parameter int ADDR_LEN     = 16,
  parameter int DATA_LEN     = 32,
  parameter int SINGLE_LEN   = 24,
  parameter int BUFFER_NUM   = 64,
  parameter int RD_LAT       = 2,
  parameter int SKID_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           conf,
  input  logic [SINGLE_LEN-1:0]          data_ddr_byte,
  input  logic [DDR_ADDR_LEN-1:0]        ddr_st_addr,
  input  logic [ADDR_LEN-1:0]            BP_st_addr,
  input  logic [1:0]                     BP_st_num,
  input  logic [SINGLE_LEN-1:0]          Line_width,
  output logic [DDR_ADDR_LEN-1:0]        ddr_st_addr_out,
  output logic [SINGLE_LEN-1:0]          ddr_len,
  output logic                           ddr_conf,
  input  logic                           ddr_fifo_full,
  output logic                           ddr_fifo_wr,
  output logic [DATA_LEN*X_MESH-1:0]     ddr_fifo_wdata,
  output logic [ADDR_LEN*BUFFER_NUM-1:0] BP_addr_out,
  output logic [BUFFER_NUM-1:0]          BP_rd_en,
  input  logic [DATA_LEN*BUFFER_NUM-1:0] BP_data_in,
  output logic                           idle
);
  localparam int BEAT_W = DATA_LEN*X_MESH;
  localparam int STAGES = RD_LAT-1;
  localparam int PTR_W  = $clog2(SKID_DEPTH);
  localparam int CNT_W  = $clog2(SKID_DEPTH+1);
  localparam int OCC_W  = CNT_W+1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state, state_nxt;

  logic [ADDR_LEN-1:0]             cfg_addr, rd_addr;
  logic [1:0]                      cfg_grp, rd_grp;
  logic [SINGLE_LEN-1:0]           cfg_width, rd_cnt;
  logic                            line, line_end, accept, issue, cap, pop;
  logic [STAGES:0]                 vld_pipe;
  logic [STAGES:0][1:0]            grp_pipe;
  logic [SKID_DEPTH-1:0][BEAT_W-1:0] skid_mem;
  logic [PTR_W-1:0]                wptr, rptr;
  logic [CNT_W-1:0]                skid_cnt;
  logic [OCC_W-1:0]                occ;
  logic [BEAT_W-1:0]               beat;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign accept   = (state == IDLE) && conf && (Line_width != '0);
  assign rd_grp   = line ? cfg_grp + 2'd1 : cfg_grp;
  assign line_end = (rd_cnt == cfg_width - 1'b1);
  assign cap      = vld_pipe[STAGES];
  // Every issued read owns a skid slot until pushed, so overflow is impossible.
  assign issue    = (state == READ) && (occ < OCC_W'(SKID_DEPTH));
  // Push straight from the skid head so a full FIFO is honoured in the same cycle.
  assign pop            = (skid_cnt != '0) && !ddr_fifo_full;
  assign ddr_fifo_wr    = pop;
  assign ddr_fifo_wdata = pop ? skid_mem[rptr] : '0;
  assign idle           = (state == IDLE);

  always_comb begin
    occ = OCC_W'(skid_cnt);
    for (int k = 0; k <= STAGES; k++) occ = occ + OCC_W'(vld_pipe[k]);
  end

  for (genvar m = 0; m < X_MESH; m++) begin : g_col
    bp_wb_col #(.X_MAC(X_MAC), .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN)) u_col (
      .issue    (issue),
      .rd_grp   (rd_grp),
      .rd_addr  (rd_addr),
      .cap_grp  (grp_pipe[STAGES]),
      .bank_data(BP_data_in[m*X_MAC*DATA_LEN +: X_MAC*DATA_LEN]),
      .rd_en    (BP_rd_en[m*X_MAC +: X_MAC]),
      .addr     (BP_addr_out[m*X_MAC*ADDR_LEN +: X_MAC*ADDR_LEN]),
      .word     (beat[m*DATA_LEN +: DATA_LEN])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    if (issue && line && line_end) state_nxt = DRAIN;
      DRAIN:   if (vld_pipe == '0 && (skid_cnt == '0 || (skid_cnt == CNT_W'(1) && pop)))
                 state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ddr_conf        <= 1'b0;
      ddr_st_addr_out <= '0;
      ddr_len         <= '0;
      cfg_addr        <= '0;
      cfg_grp         <= '0;
      cfg_width       <= '0;
      rd_addr         <= '0;
      rd_cnt          <= '0;
      line            <= 1'b0;
    end else begin
      ddr_conf <= accept;
      if (accept) begin
        ddr_st_addr_out <= ddr_st_addr;
        ddr_len         <= data_ddr_byte;
        cfg_addr        <= BP_st_addr;
        cfg_grp         <= BP_st_num;
        cfg_width       <= Line_width;
        rd_addr         <= BP_st_addr;
        rd_cnt          <= '0;
        line            <= 1'b0;
      end else if (issue) begin
        if (line_end) begin
          rd_cnt  <= '0;
          rd_addr <= cfg_addr;
          line    <= 1'b1;
        end else begin
          rd_cnt  <= rd_cnt + 1'b1;
          rd_addr <= rd_addr + 1'b1;
        end
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_pipe <= '0;
      grp_pipe <= '0;
    end else begin
      vld_pipe[0] <= issue;
      grp_pipe[0] <= rd_grp;
      for (int k = 1; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        grp_pipe[k] <= grp_pipe[k-1];
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      skid_cnt <= '0;
    end else begin
      if (cap) wptr <= ptr_inc(wptr);
      if (pop) rptr <= ptr_inc(rptr);
      skid_cnt <= skid_cnt + CNT_W'(cap) - CNT_W'(pop);
    end

  always_ff @(posedge clk)
    if (cap) skid_mem[wptr] <= beat;
endmodule

// File: tb/tb_bp_wb_fifo_control.sv
// Directed bench for bp_wb_fifo_control: behavioural banks, read/push monitor, expected beats.

module tb_bp_wb_fifo_control;
  logic          clk = 1'b0, rst_n = 1'b1, conf = 1'b0, ddr_fifo_full = 1'b0;
  logic [23:0]   data_ddr_byte = '0, Line_width = '0;
  logic [31:0]   ddr_st_addr = '0;
  logic [15:0]   BP_st_addr = '0;
  logic [1:0]    BP_st_num = '0;
  logic [31:0]   ddr_st_addr_out;
  logic [23:0]   ddr_len;
  logic          ddr_conf, ddr_fifo_wr, idle;
  logic [511:0]  ddr_fifo_wdata;
  logic [1023:0] BP_addr_out;
  logic [63:0]   BP_rd_en;
  logic [2047:0] BP_data_in;

  int checks = 0, errors = 0;

  bp_wb_fifo_control dut (
    .clk(clk), .rst_n(rst_n), .conf(conf), .data_ddr_byte(data_ddr_byte),
    .ddr_st_addr(ddr_st_addr), .BP_st_addr(BP_st_addr), .BP_st_num(BP_st_num),
    .Line_width(Line_width), .ddr_st_addr_out(ddr_st_addr_out), .ddr_len(ddr_len),
    .ddr_conf(ddr_conf), .ddr_fifo_full(ddr_fifo_full), .ddr_fifo_wr(ddr_fifo_wr),
    .ddr_fifo_wdata(ddr_fifo_wdata), .BP_addr_out(BP_addr_out), .BP_rd_en(BP_rd_en),
    .BP_data_in(BP_data_in), .idle(idle)
  );

  always #5 clk = ~clk;

  // Banks with two-cycle read latency; a read returns {bank, A5, addr}, idle banks return junk.
  logic [63:0][31:0] s1, s2;
  always_ff @(posedge clk)
    for (int b = 0; b < 64; b++) begin
      s1[b] <= BP_rd_en[b] ? {8'(b), 8'hA5, BP_addr_out[b*16 +: 16]} : {16'hDEAD, 8'h00, 8'(b)};
      s2[b] <= s1[b];
    end
  assign BP_data_in = s2;

  typedef struct packed { logic [63:0] en; logic [15:0] addr; logic same; } rd_t;
  rd_t          rd_q[$];
  logic [511:0] pu_q[$];
  int nreads = 0, npush = 0, max_out = 0, full_viol = 0, cyc = 0;
  int last_push_cyc = 0, idle_rise_cyc = 0;
  logic prev_idle = 1'b1;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (|BP_rd_en) begin
      rd_t r;
      r.en = BP_rd_en; r.addr = BP_addr_out[15:0]; r.same = 1'b1;
      for (int b = 1; b < 64; b++) if (BP_addr_out[b*16 +: 16] !== BP_addr_out[15:0]) r.same = 1'b0;
      rd_q.push_back(r);
      nreads++;
    end
    if (ddr_fifo_wr === 1'b1) begin
      pu_q.push_back(ddr_fifo_wdata);
      npush++;
      last_push_cyc = cyc;
      if (ddr_fifo_full) full_viol++;
    end
    if (nreads - npush > max_out) max_out = nreads - npush;
    if (idle === 1'b1 && prev_idle !== 1'b1) idle_rise_cyc = cyc;
    prev_idle = idle;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_mask(input logic [1:0] g);
    exp_mask = '0;
    for (int m = 0; m < 16; m++) exp_mask[int'(g) + 4*m] = 1'b1;
  endfunction

  function automatic logic [511:0] exp_beat(input logic [1:0] g, input logic [15:0] a);
    exp_beat = '0;
    for (int m = 0; m < 16; m++) exp_beat[m*32 +: 32] = {8'(int'(g) + 4*m), 8'hA5, a};
  endfunction

  task automatic clear_mon();
    rd_q.delete(); pu_q.delete();
    nreads = 0; npush = 0; max_out = 0; full_viol = 0;
  endtask

  task automatic start(input logic [31:0] da, input logic [23:0] len, input logic [15:0] sa,
                       input logic [1:0] num, input logic [23:0] w);
    @(posedge clk); #1;
    clear_mon();
    ddr_st_addr = da; data_ddr_byte = len; BP_st_addr = sa; BP_st_num = num; Line_width = w;
    conf = 1'b1;
    @(posedge clk); #1;
    conf = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (idle !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    #1;
    chk({tag, ".done"}, 512'(idle), 512'(1'b1));
  endtask

  task automatic finish_xfer(input string tag, input logic [1:0] g0, input logic [15:0] sa, input int w);
    logic [1:0] g; logic [15:0] a;
    wait_idle(tag);
    chk({tag, ".nrd"}, 512'(rd_q.size()), 512'(2*w));
    chk({tag, ".npush"}, 512'(pu_q.size()), 512'(2*w));
    for (int i = 0; i < 2*w; i++) begin
      g = (i < w) ? g0 : g0 + 2'd1;
      a = sa + 16'(i % w);
      if (i < rd_q.size()) begin
        chk($sformatf("%s.en%0d", tag, i), 512'(rd_q[i].en), 512'(exp_mask(g)));
        chk($sformatf("%s.addr%0d", tag, i), 512'(rd_q[i].addr), 512'(a));
        chk($sformatf("%s.same%0d", tag, i), 512'(rd_q[i].same), 512'(1'b1));
      end
      if (i < pu_q.size()) chk($sformatf("%s.beat%0d", tag, i), pu_q[i], exp_beat(g, a));
    end
    chk({tag, ".idlegap"}, 512'(idle_rise_cyc - last_push_cyc), 512'(1));
    chk({tag, ".fullviol"}, 512'(full_viol), 512'(0));
    chk({tag, ".maxout"}, 512'(max_out <= 4), 512'(1'b1));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst.idle", 512'(idle), 512'(1'b1));
    chk("rst.conf", 512'(ddr_conf), 512'(1'b0));
    chk("rst.wr", 512'(ddr_fifo_wr), 512'(1'b0));
    chk("rst.en", 512'(BP_rd_en), 512'(0));
    chk("rst.addr", 512'(BP_addr_out), 512'(0));
    chk("rst.len", 512'(ddr_len), 512'(0));
    chk("rst.dstart", 512'(ddr_st_addr_out), 512'(0));
    chk("rst.wdata", ddr_fifo_wdata, 512'(0));
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // Basic two-line transfer
    start(32'h1000, 24'd128, 16'd5, 2'd1, 24'd2);
    @(negedge clk);
    chk("a.conf", 512'(ddr_conf), 512'(1'b1));
    chk("a.dstart", 512'(ddr_st_addr_out), 512'(32'h1000));
    chk("a.len", 512'(ddr_len), 512'(24'd128));
    chk("a.busy", 512'(idle), 512'(1'b0));
    @(negedge clk);
    chk("a.conf1", 512'(ddr_conf), 512'(1'b0));
    finish_xfer("a", 2'd1, 16'd5, 2);
    chk("a.en0lit", 512'(rd_q[0].en), 512'(64'h2222_2222_2222_2222));
    chk("a.en2lit", 512'(rd_q[2].en), 512'(64'h4444_4444_4444_4444));
    chk("a.w0lit", 512'(pu_q[0][31:0]), 512'(32'h01A5_0005));
    chk("a.w15lit", 512'(pu_q[2][511:480]), 512'(32'h3EA5_0005));

    // Group wrap 3 -> 0
    start(32'h0, 24'd64, 16'h20, 2'd3, 24'd1);
    finish_xfer("b", 2'd3, 16'h20, 1);
    chk("b.en0lit", 512'(rd_q[0].en), 512'(64'h8888_8888_8888_8888));
    chk("b.en1lit", 512'(rd_q[1].en), 512'(64'h1111_1111_1111_1111));

    // Back-pressure after the first push
    start(32'h8000, 24'd512, 16'h40, 2'd0, 24'd8);
    for (int i = 0; i < 50 && npush == 0; i++) @(negedge clk);
    chk("c.firstpush", 512'(npush >= 1), 512'(1'b1));
    @(posedge clk); #1 ddr_fifo_full = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("c.heldpush", 512'(npush), 512'(1));
    ddr_fifo_full = 1'b0;
    finish_xfer("c", 2'd0, 16'h40, 8);

    // Address wrap
    start(32'h0, 24'd8, 16'hFFFF, 2'd2, 24'd2);
    finish_xfer("d", 2'd2, 16'hFFFF, 2);
    chk("d.a1lit", 512'(rd_q[1].addr), 512'(16'h0000));
    chk("d.a2lit", 512'(rd_q[2].addr), 512'(16'hFFFF));

    // conf while busy is ignored
    start(32'h2000, 24'd64, 16'h10, 2'd0, 24'd4);
    ddr_st_addr = 32'h3000; data_ddr_byte = 24'd99; BP_st_addr = 16'h77; BP_st_num = 2'd2;
    Line_width = 24'd1; conf = 1'b1;
    @(posedge clk); #1 conf = 1'b0;
    @(negedge clk);
    chk("e.conf", 512'(ddr_conf), 512'(1'b0));
    chk("e.dstart", 512'(ddr_st_addr_out), 512'(32'h2000));
    chk("e.len", 512'(ddr_len), 512'(24'd64));
    finish_xfer("e", 2'd0, 16'h10, 4);

    // Zero-width conf
    @(posedge clk); #1;
    clear_mon();
    Line_width = 24'd0; ddr_st_addr = 32'h5000; conf = 1'b1;
    @(posedge clk); #1 conf = 1'b0;
    @(negedge clk);
    chk("z.conf", 512'(ddr_conf), 512'(1'b0));
    chk("z.idle", 512'(idle), 512'(1'b1));
    repeat (6) @(negedge clk);
    #1;
    chk("z.nrd", 512'(rd_q.size()), 512'(0));
    chk("z.npush", 512'(pu_q.size()), 512'(0));
    chk("z.dstart", 512'(ddr_st_addr_out), 512'(32'h2000));

    // Reset mid-transfer
    start(32'h4000, 24'd32, 16'h100, 2'd1, 24'd8);
    for (int i = 0; i < 50 && npush == 0; i++) @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("f.idle", 512'(idle), 512'(1'b1));
    chk("f.wr", 512'(ddr_fifo_wr), 512'(1'b0));
    chk("f.en", 512'(BP_rd_en), 512'(0));
    chk("f.addr", 512'(BP_addr_out), 512'(0));
    chk("f.len", 512'(ddr_len), 512'(0));
    chk("f.wdata", ddr_fifo_wdata, 512'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    clear_mon();
    repeat (8) @(negedge clk);
    #1;
    chk("f.nrd", 512'(rd_q.size()), 512'(0));
    chk("f.npush", 512'(pu_q.size()), 512'(0));
    start(32'h6000, 24'd16, 16'd7, 2'd0, 24'd1);
    @(negedge clk);
    chk("g.conf", 512'(ddr_conf), 512'(1'b1));
    chk("g.dstart", 512'(ddr_st_addr_out), 512'(32'h6000));
    finish_xfer("g", 2'd0, 16'd7, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
